// File: rtl/titan_bus_pkg.sv
// Shared definitions for the two-master Wishbone bus arbiter.
//   arb_state_e    : arbiter FSM state encoding
//   GRANT_*        : one-hot grant_o encodings (bit0 = instruction, bit1 = data)
//   TIMEOUT_CYCLES_DEF : default stall limit before a forced bus error
package titan_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10,
    ABORT = 2'b11
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/bus_timeout_counter.sv
// Stall counter for a granted bus transfer.
//   clk, rst : clock, async active-low reset
//   clr      : zero the count (takes priority over en)
//   en       : one stalled cycle elapses at the next edge
//   expire   : the edge ending this cycle completes LIMIT stalled cycles
module bus_timeout_counter
  import titan_bus_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] CNT_MAX  = W'(LIMIT);
  localparam logic [W-1:0] CNT_LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // Saturates at LIMIT so the count can never wrap back to a small value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (en && cnt != CNT_MAX)  cnt <= cnt + 1'b1;
  end

  // Flag the edge that would bring the count to LIMIT, so the owner
  // is aborted after exactly LIMIT stalled cycles.
  assign expire = en && (cnt >= CNT_LAST);

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone arbiter (instruction port, data port).
//   clk, rst           : clock, async active-low reset
//   i*                 : instruction master (read-only) request / response
//   d*                 : data master request / response
//   b*                 : shared slave bus
//   grant_o            : one-hot owner, bit0 = instruction, bit1 = data
//   timeout_o          : one-cycle pulse when a stalled transfer is aborted
// Slave-side signals are a combinational mux of the owner; one bubble
// cycle in IDLE separates consecutive grants.
module wb_bus_arbiter
  import titan_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter bit FIXED_PRIO     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iaddr_i,
  input  logic [3:0]  isel_i,
  input  logic        icyc_i,
  input  logic        istb_i,
  output logic [31:0] idat_o,
  output logic        iack_o,
  output logic        ierr_o,
  input  logic [31:0] daddr_i,
  input  logic [31:0] ddat_i,
  input  logic [3:0]  dsel_i,
  input  logic        dwe_i,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  output logic [31:0] ddat_o,
  output logic        dack_o,
  output logic        derr_o,
  output logic [31:0] baddr_o,
  output logic [31:0] bdat_o,
  output logic [3:0]  bsel_o,
  output logic        bwe_o,
  output logic        bcyc_o,
  output logic        bstb_o,
  input  logic [31:0] bdat_i,
  input  logic        back_i,
  input  logic        berr_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  arb_state_e state, state_nxt;
  logic       last_d, last_d_nxt;   // 1: data port was granted most recently
  logic       abort_first;          // first cycle of ABORT
  logic       ireq, dreq, pick_d;
  logic       in_grant, owner_cyc;
  logic       tmo_clr, tmo_en, tmo_expire;

  assign ireq = icyc_i & istb_i;
  assign dreq = dcyc_i & dstb_i;

  // Data wins when alone, under fixed priority, or when it is the
  // round-robin turn (instruction held the bus last).
  assign pick_d = dreq & (~ireq | FIXED_PRIO | ~last_d);

  assign in_grant  = (state == GNT_I) || (state == GNT_D);
  // last_d is updated on grant entry, so it also names the current owner.
  assign owner_cyc = last_d ? dcyc_i : icyc_i;

  // Stalled = strobing without a response; any response restarts the window.
  assign tmo_clr = ~in_grant | back_i | berr_i;
  assign tmo_en  = in_grant & bstb_o & ~back_i & ~berr_i;

  bus_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      abort_first <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_d      <= last_d_nxt;
      abort_first <= (state_nxt == ABORT) && (state != ABORT);
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    case (state)
      IDLE: begin
        if (ireq || dreq) begin
          state_nxt  = pick_d ? GNT_D : GNT_I;
          last_d_nxt = pick_d;
        end
      end
      // Dropping cyc ends the grant even if the counter expires on the same edge.
      GNT_I: begin
        if (!icyc_i)         state_nxt = IDLE;
        else if (tmo_expire) state_nxt = ABORT;
      end
      GNT_D: begin
        if (!dcyc_i)         state_nxt = IDLE;
        else if (tmo_expire) state_nxt = ABORT;
      end
      ABORT: begin
        if (!owner_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    baddr_o = '0;
    bdat_o  = '0;
    bsel_o  = '0;
    bwe_o   = 1'b0;
    bcyc_o  = 1'b0;
    bstb_o  = 1'b0;
    idat_o  = '0;
    ddat_o  = '0;
    iack_o  = 1'b0;
    ierr_o  = 1'b0;
    dack_o  = 1'b0;
    derr_o  = 1'b0;
    grant_o = GRANT_NONE;
    case (state)
      GNT_I: begin
        grant_o = GRANT_I;
        baddr_o = iaddr_i;
        bsel_o  = isel_i;
        bcyc_o  = icyc_i;
        bstb_o  = istb_i;
        idat_o  = bdat_i;
        ddat_o  = bdat_i;
        iack_o  = back_i;
        ierr_o  = berr_i & ~back_i;  // ack wins over a simultaneous err
      end
      GNT_D: begin
        grant_o = GRANT_D;
        baddr_o = daddr_i;
        bdat_o  = ddat_i;
        bsel_o  = dsel_i;
        bwe_o   = dwe_i;
        bcyc_o  = dcyc_i;
        bstb_o  = dstb_i;
        idat_o  = bdat_i;
        ddat_o  = bdat_i;
        dack_o  = back_i;
        derr_o  = berr_i & ~back_i;
      end
      ABORT: begin
        grant_o = last_d ? GRANT_D : GRANT_I;
        ierr_o  = abort_first & ~last_d;
        derr_o  = abort_first & last_d;
      end
      default: ;
    endcase
  end

  assign timeout_o = abort_first;

endmodule
